servo_motion_sequencer: RTL

SERVO_MOTION_SEQUENCER -- requirements
Module: servo_motion_sequencer

---
 rtl/servo_motion_sequencer_pkg.sv | 47 ++++
 rtl/servo_pwm_gen.sv | 40 ++++
 rtl/servo_motion_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/servo_motion_sequencer_pkg.sv
// Shared definitions for the servo motion sequencer: PS/2 scan codes,
// decoder state encoding and active-key encoding. The display controller
// imports this package as well.
package servo_motion_sequencer_pkg;

  // Width of the frame counter and pulse arithmetic (room for 20 ms at 25 MHz).
  localparam int PULSE_W = 20;

  // PS/2 set-2 scan codes.
  localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-code prefix
  localparam logic [7:0] SC_BRK   = 8'hF0;  // break (key release) prefix
  localparam logic [7:0] SC_A     = 8'h1C;  // 'A'  -> left
  localparam logic [7:0] SC_D     = 8'h23;  // 'D'  -> right
  localparam logic [7:0] SC_S     = 8'h1B;  // 'S'  -> centre
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended arrow left
  localparam logic [7:0] SC_RIGHT = 8'h74;  // extended arrow right

  // Position targets.
  localparam logic [7:0] POS_MIN    = 8'd0;
  localparam logic [7:0] POS_MAX    = 8'd255;
  localparam logic [7:0] POS_CENTRE = 8'd128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } dec_state_e;

  typedef enum logic [1:0] {
    KEY_NONE,
    KEY_LEFT,
    KEY_RIGHT
  } key_e;

  // Which steering key a code belongs to; ext says whether E0 preceded it.
  function automatic key_e key_of(input logic [7:0] code, input logic ext);
    if ((!ext && code == SC_A) || (ext && code == SC_LEFT)) return KEY_LEFT;
    if ((!ext && code == SC_D) || (ext && code == SC_RIGHT)) return KEY_RIGHT;
    return KEY_NONE;
  endfunction

  function automatic logic is_centre(input logic [7:0] code, input logic ext);
    return !ext && (code == SC_S);
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo frame generator: free-running frame counter, pulse-width register
// and comparator. The pulse width is only reloaded on the wrap cycle, so a
// frame never carries a runt or stretched pulse.
module servo_pwm_gen
  import servo_motion_sequencer_pkg::*;
#(
  parameter int                 PERIOD_CYC = 500_000,
  parameter logic [PULSE_W-1:0] INIT_PULSE = PULSE_W'(37_544)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [PULSE_W-1:0] pulse_i,
  output logic               wrap_o,
  output logic               pwm_o
);

  logic [PULSE_W-1:0] cnt_q;
  logic [PULSE_W-1:0] pulse_q;
  logic               pwm_q;

  assign wrap_o = (cnt_q == PULSE_W'(PERIOD_CYC - 1));
  assign pwm_o  = pwm_q;

  // Frame counter, pulse register and registered (glitch-free) PWM output.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (reset_i) begin
      cnt_q   <= '0;
      pulse_q <= INIT_PULSE;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q <= wrap_o ? '0 : cnt_q + PULSE_W'(1);
      if (load_i) pulse_q <= pulse_i;
      pwm_q <= (cnt_q < pulse_q);
    end
  end

endmodule

// File: rtl/servo_motion_sequencer.sv
// Keyboard-driven servo sequencer: decodes PS/2 make/break sequences into a
// position target and slews the commanded position one unit per PWM frame.
module servo_motion_sequencer
  import servo_motion_sequencer_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int PERIOD_CYC = 500_000,
  parameter int MIN_PULSE  = 25_000,
  parameter int STEP_CYC   = 98
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan,
  input  logic       check,
  output logic       Servo_PWM,
  output logic [7:0] pos,
  output logic       busy
);

  localparam logic [PULSE_W-1:0] INIT_PULSE = PULSE_W'(MIN_PULSE + 128 * STEP_CYC);

  // Reject parameter sets whose widest pulse would not fit inside a frame.
  if (PERIOD_CYC > CLK_HZ || MIN_PULSE + 255 * STEP_CYC >= PERIOD_CYC ||
      PERIOD_CYC >= 2 ** PULSE_W) begin : g_bad_params
    $error("servo_motion_sequencer: inconsistent timing parameters");
  end

  dec_state_e         state_q, state_d;
  key_e               key_q, key_d;
  logic [7:0]         target_q, target_d;
  logic [7:0]         pos_q, pos_d;
  logic [PULSE_W-1:0] pulse_next;
  logic               wrap;
  logic               do_make, do_break, is_ext;
  key_e               code_key;

  // Scan-code decoder: prefix tracking plus the make/break command actions.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a variable unassigned and infer a latch.
    state_d  = state_q;
    key_d    = key_q;
    target_d = target_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    is_ext   = 1'b0;
    if (check) begin
      unique case (state_q)
        S_IDLE: begin
          if (scan == SC_EXT)      state_d = S_EXT;
          else if (scan == SC_BRK) state_d = S_BRK;
          else                     do_make = 1'b1;
        end
        S_EXT: begin
          if (scan == SC_BRK) state_d = S_EXT_BRK;
          else if (scan != SC_EXT) begin
            do_make = 1'b1;
            is_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          if (scan != SC_BRK) begin
            do_break = 1'b1;
            is_ext   = (state_q == S_EXT_BRK);
            state_d  = S_IDLE;
          end
        end
      endcase
    end

    code_key = key_of(scan, is_ext);

    if (do_make) begin
      if (code_key == KEY_LEFT) begin
        target_d = POS_MIN;
        key_d    = KEY_LEFT;
      end else if (code_key == KEY_RIGHT) begin
        target_d = POS_MAX;
        key_d    = KEY_RIGHT;
      end else if (is_centre(scan, is_ext)) begin
        target_d = POS_CENTRE;
        key_d    = KEY_NONE;
      end
    end

    // Releasing the key that is currently steering stops where we are.
    if (do_break && code_key != KEY_NONE && code_key == key_q) begin
      target_d = pos_q;
      key_d    = KEY_NONE;
    end
  end

  // One position step per frame toward the target held before any command
  // arriving in the same cycle; the new pulse width follows the new position.
  always_comb begin
    pos_d = pos_q;
    if (wrap) begin
      if (pos_q < target_q)      pos_d = pos_q + 8'd1;
      else if (pos_q > target_q) pos_d = pos_q - 8'd1;
    end
    pulse_next = PULSE_W'(MIN_PULSE) + PULSE_W'(pos_d) * PULSE_W'(STEP_CYC);
  end

  // Decoder, active-key, target and position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      key_q    <= KEY_NONE;
      target_q <= POS_CENTRE;
      pos_q    <= POS_CENTRE;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      target_q <= target_d;
      pos_q    <= pos_d;
    end
  end

  servo_pwm_gen #(
    .PERIOD_CYC(PERIOD_CYC),
    .INIT_PULSE(INIT_PULSE)
  ) u_pwm (
    .clk    (clk),
    .reset_i(reset),
    .load_i (wrap),
    .pulse_i(pulse_next),
    .wrap_o (wrap),
    .pwm_o  (Servo_PWM)
  );

  assign pos  = pos_q;
  assign busy = (pos_q != target_q);

endmodule
